// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, FSM state encoding and write-protect limit for the memory controller.
package mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W      = 3;

   // Highest word address of the protected region.
   localparam int unsigned WP_LIMIT = 32'h3F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic in_wp_region(input logic [31:0] addr);
      return addr <= WP_LIMIT;
   endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, 2^ADDR_W x DATA_W, registered read port with hold.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // NOTE: the storage array has no reset; only the read register is cleared, so contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: multicycle memory controller (IDLE/WAIT/ACCESS/DONE) with WAIT_CYCLES wait states.
// Define MEM_WPROT_EN to suppress writes to 0x00..0x3F and add the wp_fault output.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              AddrSel,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ready,
   output logic              req_err
`ifdef MEM_WPROT_EN
   ,
   output logic              wp_fault
`endif
);

   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              is_wr_q, is_wr_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              wp_hit;
   logic              arr_we, arr_re;

`ifdef MEM_WPROT_EN
   logic wpf_q, wpf_d;
   assign wp_hit   = is_wr_q && in_wp_region(32'(addr_q));
   assign wpf_d    = (state_q == ST_ACCESS) && wp_hit;
   assign wp_fault = wpf_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wpf_q <= 1'b0;
      else        wpf_q <= wpf_d;
   end
`else
   assign wp_hit = 1'b0;
`endif

   // NOTE: every variable gets a default up front so this block never infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (MemRead && MemWrite) begin
               state_d = ST_DONE;
               ready_d = 1'b1;
               err_d   = 1'b1;
            end else if (MemRead || MemWrite) begin
               addr_d  = AddrSel ? alu_out : pc;
               wdata_d = wdata;
               is_wr_d = MemWrite;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_ACCESS;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
            ready_d = 1'b1;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   // The array acts on the edge that leaves ACCESS, using only latched request fields.
   assign arr_we = (state_q == ST_ACCESS) && is_wr_q && !wp_hit;
   assign arr_re = (state_q == ST_ACCESS) && !is_wr_q;

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   assign mem_ready = ready_q;
   assign req_err   = err_q;

endmodule
